// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package imem_uart_loader_pkg;
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write bus driven by the loader (master) into the IMEM (slave).
interface imem_uart_loader_if #(parameter int ADDR_W = 10);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, half-bit start revalidation, centre sampling.
module uart_rx_core
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 737
) (
    input  logic       clk_85,
    input  logic       rst,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_ferr_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    // [0],[1] synchroniser, [2] previous synchronised value for edge detect
    logic [2:0]    sync_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;

    always_ff @(posedge clk_85) begin
        if (rst) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !sync_q[1]) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {sync_q[1], sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                state_d = RX_IDLE;
                valid_d = sync_q[1];
                ferr_d  = !sync_q[1];
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid_o = valid_q;
    assign rx_byte_o  = sh_q;
    assign rx_ferr_o  = ferr_q;
endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: framed byte stream -> sequential IMEM word writes, holds CPU until checksum OK.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_FREQ       = 85000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 10,
    parameter int IMEM_DEPTH     = 1024,
    parameter int TIMEOUT_CYCLES = 8500000
) (
    input  logic                clk_85,
    input  logic                rst,
    input  logic                uart_rx_i,
    imem_uart_loader_if.master  imem,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [15:0]         words_loaded
);
    if (TIMEOUT_CYCLES < 1 || IMEM_DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
        $error("imem_uart_loader: invalid TIMEOUT_CYCLES/IMEM_DEPTH");
    end

    logic       rx_valid, rx_ferr, tmo_hit;
    logic [7:0] rx_byte;

    uart_rx_core #(.CLKS_PER_BIT(CLK_FREQ / BAUD)) u_rx (
        .clk_85     (clk_85),
        .rst        (rst),
        .rx_i       (uart_rx_i),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte),
        .rx_ferr_o  (rx_ferr)
    );

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       words_q, words_d, len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic              loading;

    assign loading = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CHECK);

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q;
    always_ff @(posedge clk_85) begin
        if (rst || !loading || rx_valid) tmo_q <= '0;
        else                             tmo_q <= tmo_q + 32'd1;
    end
    assign tmo_hit = loading && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_85) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            words_q <= '0;
            len_q   <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            bcnt_q  <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            len_q   <= len_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            bcnt_q  <= bcnt_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        len_d   = len_q;
        word_d  = word_q;
        chk_d   = chk_q;
        bcnt_d  = bcnt_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                // Status flags follow the state one cycle after entry
                if (state_q == DONE) begin done_d = 1'b1; hold_d = 1'b0; end
                if (state_q == ERR)  err_d = 1'b1;
                if (rx_valid && rx_byte == LOADER_SYNC_BYTE) begin
                    state_d = LEN_LO;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    idx_d   = '0;
                    chk_d   = '0;
                    bcnt_d  = '0;
                end
            end
            LEN_LO: if (rx_valid) begin
                len_d[7:0] = rx_byte;
                state_d    = LEN_HI;
            end
            LEN_HI: if (rx_valid) begin
                len_d[15:8] = rx_byte;
                if ({rx_byte, len_q[7:0]} > 16'(IMEM_DEPTH)) state_d = ERR;
                else if ({rx_byte, len_q[7:0]} == 16'd0)     state_d = CHECK;
                else                                         state_d = DATA;
            end
            DATA: begin
                if (we_q) begin
                    idx_d   = idx_q + ADDR_W'(1);
                    words_d = words_q + 16'd1;
                    if (words_q + 16'd1 == len_q) state_d = CHECK;
                end else if (rx_valid) begin
                    word_d = {rx_byte, word_q[31:8]};
                    chk_d  = chk_q ^ rx_byte;
                    bcnt_d = bcnt_q + 2'd1;
                    we_d   = (bcnt_q == 2'd3);
                end
            end
            CHECK: if (rx_valid) state_d = (rx_byte == chk_q) ? DONE : ERR;
            default: state_d = IDLE;
        endcase
        if (loading && (rx_ferr || tmo_hit)) begin
            state_d = ERR;
            we_d    = 1'b0;
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = idx_q;
    assign imem.imem_wdata = word_q;
    assign cpu_hold        = hold_q;
    assign load_done       = done_q;
    assign load_err        = err_q;
    assign words_loaded    = words_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with a shortened bit time (16 clocks per bit).
module tb_imem_uart_loader;
    localparam int CPB = 16;

    logic        clk_85 = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        cpu_hold, load_done, load_err;
    logic [15:0] words_loaded;

    imem_uart_loader_if #(.ADDR_W(10)) imem_bus ();

    imem_uart_loader #(
        .CLK_FREQ(16), .BAUD(1), .ADDR_W(10), .IMEM_DEPTH(1024), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk_85       (clk_85),
        .rst          (rst),
        .uart_rx_i    (rx),
        .imem         (imem_bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk_85 = ~clk_85;

    // Write log: every imem_we pulse, sampled away from the active edge
    int          we_total = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    always @(negedge clk_85) begin
        if (imem_bus.imem_we === 1'b1) begin
            if (we_total < 64) begin
                wr_addr[we_total] = 32'(imem_bus.imem_addr);
                wr_data[we_total] = imem_bus.imem_wdata;
            end
            we_total = we_total + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int base;
    logic [7:0] frame[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk_85);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_85);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk_85);
        end
        rx = stop;
        repeat (CPB) @(negedge clk_85);
        rx = 1'b1;
        repeat (CPB) @(negedge clk_85);
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (8) @(negedge clk_85);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_85);
        rst = 1'b0;
        @(negedge clk_85);
    endtask

    initial begin
        repeat (4) @(negedge clk_85);
        check("reset_hold_during", 32'(cpu_hold), 32'd1);
        rst = 1'b0;
        @(negedge clk_85);
        check("reset_hold", 32'(cpu_hold), 32'd1);
        check("reset_done", 32'(load_done), 32'd0);
        check("reset_err", 32'(load_err), 32'd0);
        check("reset_words", 32'(words_loaded), 32'd0);
        check("reset_we", 32'(imem_bus.imem_we), 32'd0);

        // Valid two-word load
        base = we_total;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                  8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        send_frame(frame);
        check("valid_we_cnt", 32'(we_total - base), 32'd2);
        check("valid_addr0", wr_addr[base], 32'd0);
        check("valid_data0", wr_data[base], 32'h00500093);
        check("valid_addr1", wr_addr[base+1], 32'd1);
        check("valid_data1", wr_data[base+1], 32'h00A00113);
        check("valid_words", 32'(words_loaded), 32'd2);
        check("valid_done", 32'(load_done), 32'd1);
        check("valid_err", 32'(load_err), 32'd0);
        check("valid_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum: words still written, load fails
        base = we_total;
        frame[11] = 8'h70;
        send_frame(frame);
        check("badchk_we_cnt", 32'(we_total - base), 32'd2);
        check("badchk_data1", wr_data[base+1], 32'h00A00113);
        check("badchk_words", 32'(words_loaded), 32'd2);
        check("badchk_err", 32'(load_err), 32'd1);
        check("badchk_done", 32'(load_done), 32'd0);
        check("badchk_hold", 32'(cpu_hold), 32'd1);

        // Oversize N=1025
        base = we_total;
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame(frame);
        check("oversize_we_cnt", 32'(we_total - base), 32'd0);
        check("oversize_err", 32'(load_err), 32'd1);
        check("oversize_words", 32'(words_loaded), 32'd0);
        check("oversize_hold", 32'(cpu_hold), 32'd1);

        // Empty load
        base = we_total;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(frame);
        check("empty_we_cnt", 32'(we_total - base), 32'd0);
        check("empty_done", 32'(load_done), 32'd1);
        check("empty_err", 32'(load_err), 32'd0);
        check("empty_hold", 32'(cpu_hold), 32'd0);

        // Framing error on the 3rd data byte, then a good load overwriting address 0
        base = we_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (8) @(negedge clk_85);
        check("ferr_err", 32'(load_err), 32'd1);
        check("ferr_hold", 32'(cpu_hold), 32'd1);
        check("ferr_we_cnt", 32'(we_total - base), 32'd0);
        frame = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_frame(frame);
        check("reload_we_cnt", 32'(we_total - base), 32'd1);
        check("reload_addr", wr_addr[base], 32'd0);
        check("reload_data", wr_data[base], 32'hDEADBEEF);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_words", 32'(words_loaded), 32'd1);

        // Reset mid-DATA: one word in, reset, trailing bytes must not write
        base = we_total;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(frame);
        check("middata_words", 32'(words_loaded), 32'd1);
        check("middata_data0", wr_data[base], 32'h04030201);
        rst = 1'b1;
        repeat (2) @(negedge clk_85);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        frame = '{8'h07, 8'h08, 8'h0F};
        send_frame(frame);
        check("postrst_we_cnt", 32'(we_total - base), 32'd1);
        check("postrst_words", 32'(words_loaded), 32'd0);
        check("postrst_done", 32'(load_done), 32'd0);
        check("postrst_err", 32'(load_err), 32'd0);
        check("postrst_hold", 32'(cpu_hold), 32'd1);

`ifdef LOADER_TIMEOUT_EN
        // Stall after the length bytes: error once 1000 idle cycles elapse
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (900) @(negedge clk_85);
        check("tmo_err_early", 32'(load_err), 32'd0);
        repeat (200) @(negedge clk_85);
        check("tmo_err", 32'(load_err), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
`else
        do_reset();
        check("final_reset_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
UART boot loader that writes programs into instruction memory. It is the write side of the instruction memory that instruction_fetch_stage reads.
- Receives a framed byte stream on a UART RX pin and assembles little-endian 32-bit words.
- Writes the words sequentially from word address 0.
- Holds the CPU pipeline in reset (cpu_hold) until a load completes with a valid checksum.
- Sits beside the pipeline in top, on the clk_85 domain.

Parameters:
CLK_FREQ, 85000000, clk_85 frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 737)
ADDR_W, 10, instruction memory word-address width
IMEM_DEPTH, 1024, maximum words per load
TIMEOUT_CYCLES, 8500000, inter-byte timeout (100 ms); used only with LOADER_TIMEOUT_EN

Ports:
clk_85  in  1  clock, 85 MHz
rst  in  1  synchronous, active-high reset
uart_rx_i  in  1  asynchronous serial input, idle high
imem_we  out  1  one-cycle instruction memory write strobe
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  word to write
cpu_hold  out  1  high = keep pipeline in reset
load_done  out  1  level; last load succeeded
load_err  out  1  level; last load failed
words_loaded  out  16  number of words written in the current or last load

Behaviour:
- Reset values:
  - cpu_hold=1; every other output 0.
  - FSM in IDLE; UART RX core idle.
- Reset is honoured mid-frame and mid-load: abort immediately, no further writes.
- RX core:
  - 2-FF synchroniser on uart_rx_i.
  - Start detected on a falling edge, revalidated at half-bit: still low, else return to idle.
  - Data sampled at each bit centre, LSB first.
  - Stop bit sampled at centre; 0 = framing error.
  - Outputs: rx_valid (1 cycle), rx_byte[7:0], rx_ferr (1 cycle).
- Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count N, little-endian), 4*N data bytes (each word little-endian), CHK.
  - CHK = XOR of all 4*N data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
  - IDLE/DONE/ERR: rx byte 0xA5 → LEN_LO.
    - On this transition: cpu_hold=1, load_done=0, load_err=0, words_loaded=0, address=0, checksum=0.
    - Any other byte is ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI:
    - N > IMEM_DEPTH → ERR.
    - N == 0 → CHECK.
    - Otherwise → DATA.
  - DATA:
    - Shift bytes into a word register and XOR each into the checksum.
    - The cycle after the 4th byte's rx_valid: imem_we=1 with imem_addr=current index and imem_wdata=assembled word.
    - On that same cycle: index+1, words_loaded+1.
    - After word N is written → CHECK.
  - CHECK:
    - Next byte equal to the checksum → DONE: load_done=1, cpu_hold=0 one cycle after entry.
    - Byte not equal → ERR: load_err=1, cpu_hold stays 1.
- rx_ferr in any state other than IDLE/DONE/ERR → ERR. In IDLE/DONE/ERR it is ignored.
- Address never wraps: N ≤ IMEM_DEPTH is enforced, so the maximum index is IMEM_DEPTH-1.
- imem_we is never asserted outside DATA.
- Words already written before an error stay in memory; cpu_hold keeps the CPU from running them.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - In LEN_LO, LEN_HI, DATA and CHECK, a counter reloads on every rx_valid.
  - Reaching TIMEOUT_CYCLES with no byte → ERR (load_err=1).
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- common_pkg gains:
  - loader_state_t enum.
  - LOADER_SYNC_BYTE = 8'hA5.
- Sub-module uart_rx_core (parameter CLKS_PER_BIT), containing the synchroniser, bit timer and shift register.
- Framing FSM, word assembly and checksum stay in imem_uart_loader.

Test Plan:
- Valid load: send A5 02 00 93 00 50 00 13 01 A0 00 71 →
  - Write 0x00500093 @0, then 0x00A00113 @1.
  - words_loaded=2, load_done=1, cpu_hold falls.
- Bad checksum: same frame with last byte 0x70 → both writes occur, then load_err=1 and cpu_hold stays 1.
- Oversize: A5 01 04 (N=1025) → ERR immediately, zero imem_we pulses.
- Empty load: A5 00 00 00 → DONE, no writes, cpu_hold=0.
- Framing error: stop bit forced low on the 3rd data byte → ERR. A following valid frame → DONE and overwrites from address 0.
- Reset/timeout: assert rst mid-DATA → all outputs return to reset values with no further writes. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stall after LEN_HI → load_err=1 at 1000 cycles.
